// File: rtl/riscv_instr_mem_responder.sv
// Instruction-fetch responder: OBI-style req/gnt/rvalid front end over a word RAM
// with a fixed-latency in-order response pipeline and a side preload write port.
module riscv_instr_mem_responder #(
    parameter int unsigned DEPTH           = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   instr_req_i,
    input  logic [31:0]                            instr_addr_i,
    output logic                                   instr_gnt_o,
    output logic                                   instr_rvalid_o,
    output logic [31:0]                            instr_rdata_o,
    output logic                                   instr_err_o,
    input  logic                                   stall_i,
    input  logic                                   we_i,
    input  logic [$clog2(DEPTH)-1:0]               waddr_i,
    input  logic [31:0]                            wdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $fatal(1, "riscv_instr_mem_responder: LATENCY must be 1..4");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_outstanding
        $fatal(1, "riscv_instr_mem_responder: MAX_OUTSTANDING must be 1..LATENCY+1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "riscv_instr_mem_responder: DEPTH must be a power of 2");
    end

    logic [31:0]         mem [DEPTH];

    logic [32:0]         diff_c;
    logic                in_range_c;
    logic [AW-1:0]       ridx_c;
    logic [31:0]         rd_word_c;
    logic                retire_c;
    logic                gnt_c;

    logic [LATENCY-1:0]  vld_q, vld_d;
    logic [LATENCY-1:0]  err_q, err_d;
    logic [31:0]         data_q [LATENCY];
    logic [31:0]         data_d [LATENCY];
    logic [CW-1:0]       outst_q, outst_d;

    // Addresses below BASE_ADDR make diff_c negative (bit 32 set), so one compare covers both bounds.
    always_comb begin
        diff_c     = {1'b0, instr_addr_i} - {1'b0, BASE_ADDR};
        in_range_c = diff_c < SPAN;
        ridx_c     = AW'(diff_c >> 2);
        rd_word_c  = in_range_c ? mem[ridx_c] : 32'd0;
    end

    always_comb begin
        retire_c = vld_q[LATENCY-1];
        gnt_c    = instr_req_i & ~stall_i & ~rst &
                   ((outst_q < CW'(MAX_OUTSTANDING)) | retire_c);

        vld_d  = '0;
        err_d  = err_q;
        data_d = data_q;

        vld_d[0] = gnt_c;
        if (gnt_c) begin
            data_d[0] = rd_word_c;
            err_d[0]  = ~in_range_c;
        end
        // Payload only advances behind a valid entry so the last stage holds the previous response.
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                data_d[i] = data_q[i-1];
                err_d[i]  = err_q[i-1];
            end
        end

        outst_d = outst_q + CW'(gnt_c) - CW'(retire_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            err_q   <= '0;
            outst_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= 32'd0;
            end
        end else begin
            vld_q   <= vld_d;
            err_q   <= err_d;
            outst_q <= outst_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Preload port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign instr_gnt_o    = gnt_c;
    assign instr_rvalid_o = vld_q[LATENCY-1];
    assign instr_rdata_o  = data_q[LATENCY-1];
    assign instr_err_o    = err_q[LATENCY-1];
    assign outstanding_o  = outst_q;

    a_gnt_needs_req : assert property (@(posedge clk) instr_gnt_o |-> instr_req_i);
    a_rvalid_needs_outstanding : assert property (@(posedge clk) disable iff (rst)
        instr_rvalid_o |-> (outst_q != '0));

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Directed bench for riscv_instr_mem_responder: a LATENCY=1 and a LATENCY=3 instance
// driven on the falling edge and checked 1 time unit later.
module tb_riscv_instr_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, req1, gnt1, rvalid1, err1, stall1, we1;
    logic [31:0] addr1, rdata1, wdata1;
    logic [9:0]  waddr1;
    logic [1:0]  out1;

    logic        rst3, req3, gnt3, rvalid3, err3, stall3, we3;
    logic [31:0] addr3, rdata3, wdata3;
    logic [9:0]  waddr3;
    logic [1:0]  out3;

    int n_vec = 0;
    int n_err = 0;

    riscv_instr_mem_responder #(
        .DEPTH(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(1), .MAX_OUTSTANDING(2)
    ) u_dut1 (
        .clk(clk), .rst(rst1),
        .instr_req_i(req1), .instr_addr_i(addr1), .instr_gnt_o(gnt1),
        .instr_rvalid_o(rvalid1), .instr_rdata_o(rdata1), .instr_err_o(err1),
        .stall_i(stall1), .we_i(we1), .waddr_i(waddr1), .wdata_i(wdata1),
        .outstanding_o(out1)
    );

    riscv_instr_mem_responder #(
        .DEPTH(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(3), .MAX_OUTSTANDING(2)
    ) u_dut3 (
        .clk(clk), .rst(rst3),
        .instr_req_i(req3), .instr_addr_i(addr3), .instr_gnt_o(gnt3),
        .instr_rvalid_o(rvalid3), .instr_rdata_o(rdata3), .instr_err_o(err3),
        .stall_i(stall3), .we_i(we3), .waddr_i(waddr3), .wdata_i(wdata3),
        .outstanding_o(out3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic drive1(input logic req, input logic [31:0] addr, input logic stall,
                          input logic we, input logic [9:0] wa, input logic [31:0] wd);
        @(negedge clk);
        req1 = req; addr1 = addr; stall1 = stall; we1 = we; waddr1 = wa; wdata1 = wd;
        #1;
    endtask

    task automatic drive3(input logic r, input logic req, input logic [31:0] addr,
                          input logic we, input logic [9:0] wa, input logic [31:0] wd);
        @(negedge clk);
        rst3 = r; req3 = req; addr3 = addr; we3 = we; waddr3 = wa; wdata3 = wd;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] b_addr [4];
        logic [31:0] b_data [4];
        b_addr = '{32'h0, 32'h8, 32'h14, 32'h0};
        b_data = '{32'h0000_0A0A, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_0A0A};

        rst1 = 1'b1; req1 = 1'b1; addr1 = 32'h0; stall1 = 1'b0; we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        rst3 = 1'b1; req3 = 1'b1; addr3 = 32'h0; stall3 = 1'b0; we3 = 1'b0; waddr3 = '0; wdata3 = '0;

        // Reset state, with req held high to confirm gnt stays low under reset
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);
        chk("rst_out1", 32'(out1), 32'd0);
        chk("rst_gnt3", 32'(gnt3), 32'd0);
        chk("rst_out3", 32'(out3), 32'd0);
        rst1 = 1'b0; req1 = 1'b0; rst3 = 1'b0; req3 = 1'b0;

        // Preload
        drive1(0, 0, 0, 1, 10'd5, 32'hDEAD_BEEF);
        drive1(0, 0, 0, 1, 10'd2, 32'h2222_2222);
        drive1(0, 0, 0, 1, 10'd0, 32'h0000_0A0A);
        drive3(0, 0, 0, 1, 10'd0, 32'h3000_0000);
        drive3(0, 0, 0, 1, 10'd1, 32'h3000_0004);
        drive3(0, 0, 0, 0, 10'd2, 32'h3000_0008);
        drive3(0, 0, 0, 1, 10'd2, 32'h3000_0008);
        drive3(0, 0, 0, 0, 10'd0, 32'h0);

        // Single read, LATENCY 1
        drive1(1, 32'h14, 0, 0, 0, 0);
        chk("t1_gnt", 32'(gnt1), 32'd1);
        chk("t1_out_before", 32'(out1), 32'd0);
        chk("t1_rvalid_before", 32'(rvalid1), 32'd0);
        drive1(0, 0, 0, 0, 0, 0);
        chk("t1_gnt_noreq", 32'(gnt1), 32'd0);
        chk("t1_rvalid", 32'(rvalid1), 32'd1);
        chk("t1_rdata", rdata1, 32'hDEAD_BEEF);
        chk("t1_err", 32'(err1), 32'd0);
        chk("t1_out_during", 32'(out1), 32'd1);
        drive1(0, 0, 0, 0, 0, 0);
        chk("t1_rvalid_after", 32'(rvalid1), 32'd0);
        chk("t1_out_after", 32'(out1), 32'd0);
        chk("t1_rdata_hold", rdata1, 32'hDEAD_BEEF);

        // Out-of-range at top boundary and at an aliasing address, then in-range
        drive1(1, 32'h1000, 0, 0, 0, 0);
        chk("oor_gnt", 32'(gnt1), 32'd1);
        drive1(1, 32'h1014, 0, 0, 0, 0);
        chk("oor_rvalid", 32'(rvalid1), 32'd1);
        chk("oor_err", 32'(err1), 32'd1);
        chk("oor_rdata", rdata1, 32'd0);
        chk("oor_gnt_retire", 32'(gnt1), 32'd1);
        drive1(1, 32'h0, 0, 0, 0, 0);
        chk("alias_err", 32'(err1), 32'd1);
        chk("alias_rdata", rdata1, 32'd0);
        drive1(0, 0, 0, 0, 0, 0);
        chk("inr_rvalid", 32'(rvalid1), 32'd1);
        chk("inr_err", 32'(err1), 32'd0);
        chk("inr_rdata", rdata1, 32'h0000_0A0A);

        // Same-cycle write and read of word 2 returns the old data
        drive1(1, 32'h8, 0, 1, 10'd2, 32'h1111_1111);
        chk("rbw_gnt", 32'(gnt1), 32'd1);
        drive1(1, 32'h8, 0, 0, 0, 0);
        chk("rbw_old", rdata1, 32'h2222_2222);
        chk("rbw_gnt2", 32'(gnt1), 32'd1);
        drive1(0, 0, 0, 0, 0, 0);
        chk("rbw_new", rdata1, 32'h1111_1111);

        // Back-to-back reads: gnt every cycle, rvalid every cycle after the first
        for (int k = 0; k < 4; k++) begin
            drive1(1, b_addr[k], 0, 0, 0, 0);
            chk("b2b_gnt", 32'(gnt1), 32'd1);
            if (k > 0) begin
                chk("b2b_rvalid", 32'(rvalid1), 32'd1);
                chk("b2b_rdata", rdata1, b_data[k-1]);
            end
        end
        drive1(0, 0, 0, 0, 0, 0);
        chk("b2b_last_rdata", rdata1, b_data[3]);
        chk("b2b_out", 32'(out1), 32'd1);
        drive1(0, 0, 0, 0, 0, 0);

        // Stall with one response in flight
        drive1(1, 32'h14, 0, 0, 0, 0);
        chk("stall_first_gnt", 32'(gnt1), 32'd1);
        for (int s = 0; s < 4; s++) begin
            drive1(1, 32'h14, 1, 0, 0, 0);
            chk("stall_gnt", 32'(gnt1), 32'd0);
            chk("stall_rvalid", 32'(rvalid1), (s == 0) ? 32'd1 : 32'd0);
        end
        chk("stall_rdata", rdata1, 32'hDEAD_BEEF);
        drive1(1, 32'h14, 0, 0, 0, 0);
        chk("stall_resume_gnt", 32'(gnt1), 32'd1);
        drive1(0, 0, 0, 0, 0, 0);
        chk("stall_resume_rvalid", 32'(rvalid1), 32'd1);

        // LATENCY 3, MAX_OUTSTANDING 2 throughput limit
        drive3(0, 1, 32'h0, 0, 0, 0);
        chk("l3_c0_gnt", 32'(gnt3), 32'd1);
        chk("l3_c0_out", 32'(out3), 32'd0);
        drive3(0, 1, 32'h4, 0, 0, 0);
        chk("l3_c1_gnt", 32'(gnt3), 32'd1);
        chk("l3_c1_out", 32'(out3), 32'd1);
        drive3(0, 1, 32'h8, 0, 0, 0);
        chk("l3_c2_gnt", 32'(gnt3), 32'd0);
        chk("l3_c2_out", 32'(out3), 32'd2);
        chk("l3_c2_rvalid", 32'(rvalid3), 32'd0);
        drive3(0, 1, 32'h8, 0, 0, 0);
        chk("l3_c3_gnt", 32'(gnt3), 32'd1);
        chk("l3_c3_rvalid", 32'(rvalid3), 32'd1);
        chk("l3_c3_rdata", rdata3, 32'h3000_0000);
        chk("l3_c3_out", 32'(out3), 32'd2);
        drive3(0, 0, 32'h0, 0, 0, 0);
        chk("l3_c4_rvalid", 32'(rvalid3), 32'd1);
        chk("l3_c4_rdata", rdata3, 32'h3000_0004);
        chk("l3_c4_out", 32'(out3), 32'd2);
        drive3(0, 0, 32'h0, 0, 0, 0);
        chk("l3_c5_rvalid", 32'(rvalid3), 32'd0);
        chk("l3_c5_hold", rdata3, 32'h3000_0004);
        chk("l3_c5_out", 32'(out3), 32'd1);
        drive3(0, 0, 32'h0, 0, 0, 0);
        chk("l3_c6_rvalid", 32'(rvalid3), 32'd1);
        chk("l3_c6_rdata", rdata3, 32'h3000_0008);
        chk("l3_c6_err", 32'(err3), 32'd0);
        drive3(0, 0, 32'h0, 0, 0, 0);
        chk("l3_c7_out", 32'(out3), 32'd0);

        // Reset with two responses in flight
        drive3(0, 1, 32'h0, 0, 0, 0);
        chk("mr_r0_gnt", 32'(gnt3), 32'd1);
        drive3(0, 1, 32'h4, 0, 0, 0);
        chk("mr_r1_gnt", 32'(gnt3), 32'd1);
        drive3(1, 1, 32'h8, 0, 0, 0);
        chk("mr_r2_gnt_in_rst", 32'(gnt3), 32'd0);
        chk("mr_r2_out", 32'(out3), 32'd2);
        drive3(0, 0, 32'h0, 0, 0, 0);
        chk("mr_r3_rvalid", 32'(rvalid3), 32'd0);
        chk("mr_r3_out", 32'(out3), 32'd0);
        chk("mr_r3_rdata", rdata3, 32'd0);
        for (int j = 0; j < 2; j++) begin
            drive3(0, 0, 32'h0, 0, 0, 0);
            chk("mr_drained_rvalid", 32'(rvalid3), 32'd0);
        end
        drive3(0, 1, 32'h8, 0, 0, 0);
        chk("mr_post_gnt", 32'(gnt3), 32'd1);
        for (int j = 0; j < 2; j++) begin
            drive3(0, 0, 32'h0, 0, 0, 0);
            chk("mr_post_wait_rvalid", 32'(rvalid3), 32'd0);
        end
        drive3(0, 0, 32'h0, 0, 0, 0);
        chk("mr_post_rvalid", 32'(rvalid3), 32'd1);
        chk("mr_post_rdata", rdata3, 32'h3000_0008);
        chk("mr_post_err", 32'(err3), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
